// File: rtl/uart_rx_fifo.sv
// UART receiver with configurable width, parity and stop bits, feeding a show-ahead RX FIFO.
// Parity, framing and overrun errors are reported through sticky flags.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 8,
  localparam int ADDR_W      = $clog2(FIFO_DEPTH)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_uart_rxd,
  input  logic                 i_rd_en,
  input  logic                 i_clr_err,
  output logic [DATA_BITS-1:0] o_rx_data,
  output logic                 o_empty,
  output logic                 o_full,
  output logic [ADDR_W:0]      o_count,
  output logic                 o_rx_dv,
  output logic                 o_parity_err,
  output logic                 o_frame_err,
  output logic                 o_overrun
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic ODD_PAR = (PARITY == 2);
  localparam logic [ADDR_W:0] DEPTH_CNT = FIFO_DEPTH[ADDR_W:0];

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  logic sync1_reg, sync2_reg, rxd;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= i_uart_rxd;
      sync2_reg <= sync1_reg;
    end
  end

  assign rxd = sync2_reg;

  state_t                 state_reg, state_next;
  logic [CNT_W-1:0]       clk_cnt_reg, clk_cnt_next;
  logic [3:0]             bit_cnt_reg, bit_cnt_next;
  logic [DATA_BITS-1:0]   shift_reg, shift_next;
  logic                   parity_bad_reg, parity_bad_next;
  logic                   stop_bad_reg, stop_bad_next;
  logic                   commit_reg, commit_next;
  logic                   commit_ferr_reg, commit_ferr_next;
  logic                   sample;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg       <= S_IDLE;
      clk_cnt_reg     <= '0;
      bit_cnt_reg     <= '0;
      shift_reg       <= '0;
      parity_bad_reg  <= 1'b0;
      stop_bad_reg    <= 1'b0;
      commit_reg      <= 1'b0;
      commit_ferr_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      clk_cnt_reg     <= clk_cnt_next;
      bit_cnt_reg     <= bit_cnt_next;
      shift_reg       <= shift_next;
      parity_bad_reg  <= parity_bad_next;
      stop_bad_reg    <= stop_bad_next;
      commit_reg      <= commit_next;
      commit_ferr_reg <= commit_ferr_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    clk_cnt_next     = clk_cnt_reg;
    bit_cnt_next     = bit_cnt_reg;
    shift_next       = shift_reg;
    parity_bad_next  = parity_bad_reg;
    stop_bad_next    = stop_bad_reg;
    commit_next      = 1'b0;
    commit_ferr_next = 1'b0;
    sample           = (clk_cnt_reg == CNT_LAST);
    case (state_reg)
      S_IDLE: begin
        if (!rxd) begin
          state_next   = S_START;
          clk_cnt_next = '0;
        end
      end
      S_START: begin
        if (clk_cnt_reg == CNT_HALF) begin
          clk_cnt_next = '0;
          bit_cnt_next = '0;
          state_next   = rxd ? S_IDLE : S_DATA;
        end else begin
          clk_cnt_next = clk_cnt_reg + 1'b1;
        end
      end
      S_DATA: begin
        if (sample) begin
          clk_cnt_next = '0;
          shift_next   = {rxd, shift_reg[DATA_BITS-1:1]};
          if (bit_cnt_reg == DATA_LAST) begin
            bit_cnt_next    = '0;
            parity_bad_next = 1'b0;
            stop_bad_next   = 1'b0;
            state_next      = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_next = bit_cnt_reg + 1'b1;
          end
        end else begin
          clk_cnt_next = clk_cnt_reg + 1'b1;
        end
      end
      S_PARITY: begin
        if (sample) begin
          clk_cnt_next    = '0;
          parity_bad_next = (^shift_reg) ^ rxd ^ ODD_PAR;
          state_next      = S_STOP;
        end else begin
          clk_cnt_next = clk_cnt_reg + 1'b1;
        end
      end
      S_STOP: begin
        if (sample) begin
          clk_cnt_next = '0;
          // Decision is registered here; the FIFO write happens on the following edge.
          if (bit_cnt_reg == STOP_LAST) begin
            commit_next      = 1'b1;
            commit_ferr_next = stop_bad_reg | ~rxd;
            state_next       = (stop_bad_reg | ~rxd) ? S_WAIT_HIGH : S_IDLE;
          end else begin
            bit_cnt_next  = bit_cnt_reg + 1'b1;
            stop_bad_next = stop_bad_reg | ~rxd;
          end
        end else begin
          clk_cnt_next = clk_cnt_reg + 1'b1;
        end
      end
      S_WAIT_HIGH: begin
        if (rxd) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [ADDR_W:0]      count_reg;
  logic                 dv_reg, perr_reg, ferr_reg, ovr_reg;
  logic                 frame_good, pop, push;
  logic                 set_perr, set_ferr, set_ovr;

  assign frame_good = commit_reg & ~commit_ferr_reg & ~parity_bad_reg;
  assign pop        = i_rd_en & ~o_empty;
  // A pop in the commit cycle frees the slot, so a full FIFO still accepts the frame.
  assign push       = frame_good & (~o_full | pop);
  assign set_ferr   = commit_reg & commit_ferr_reg;
  assign set_perr   = commit_reg & ~commit_ferr_reg & parity_bad_reg;
  assign set_ovr    = frame_good & o_full & ~pop;

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr_reg] <= shift_reg;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      dv_reg     <= 1'b0;
      perr_reg   <= 1'b0;
      ferr_reg   <= 1'b0;
      ovr_reg    <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
      dv_reg   <= push;
      perr_reg <= (perr_reg & ~i_clr_err) | set_perr;
      ferr_reg <= (ferr_reg & ~i_clr_err) | set_ferr;
      ovr_reg  <= (ovr_reg  & ~i_clr_err) | set_ovr;
    end
  end

  assign o_empty      = (count_reg == '0);
  assign o_full       = (count_reg == DEPTH_CNT);
  assign o_count      = count_reg;
  assign o_rx_data    = o_empty ? '0 : mem[rd_ptr_reg];
  assign o_rx_dv      = dv_reg;
  assign o_parity_err = perr_reg;
  assign o_frame_err  = ferr_reg;
  assign o_overrun    = ovr_reg;

endmodule
